// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the cache-to-memory link: responder FSM states,
// word/offset geometry and the latency-counter width helper.
package main_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int OFFSET_W   = 2;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Width needed to hold a count of 0..latency.
  function automatic int cnt_w(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-to-memory bus: one request channel (valid/ready, we, addr, wdata)
// and one response channel (valid/ready, we echo, data).
//   master : the cache side, drives requests and consumes responses
//   slave  : the memory side, accepts requests and produces responses
interface main_memory_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_we;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_data
  );
endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Single-port synchronous word RAM, read-first on write.
//   CLK    : clock
//   en     : access strobe (read, or read+write when we=1)
//   we     : commit wdata at index
//   index  : word index
//   wdata  : write data
//   rdata  : registered read data (old contents on a write), held when en=0
module main_memory_responder_mem_array #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              CLK,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) mem[index] <= wdata;
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: serves cache line fills and writebacks with a fixed
// access latency, one outstanding request at a time.
//   CLK   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of the cache-to-memory interface
// A request accepted at edge k raises resp_valid after edge k+LATENCY; the
// storage access (read or write commit) happens on that same edge.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  main_memory_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept, complete;

  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_we_q;
  logic              rd_sel_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] ram_rdata;

  // Byte offset and bits above the index never select storage.
  logic addr_unused;
  assign addr_unused = ^{bus.req_addr[ADDR_W-1:IDX_W+OFFSET_W], bus.req_addr[OFFSET_W-1:0]};

  assign accept   = (state == IDLE) && bus.req_valid;
  assign complete = (state == BUSY) && (cnt == '0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs depend on state only.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter and response control.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      resp_we_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      wb_data_q <= '0;
    end else begin
      if (accept)                 cnt <= CNT_LOAD;
      else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (complete) begin
        resp_we_q <= we_q;
        rd_sel_q  <= ~we_q;
        if (we_q) wb_data_q <= wdata_q;
      end
    end
  end

  // Request capture.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= bus.req_we;
      idx_q   <= bus.req_addr[IDX_W+OFFSET_W-1:OFFSET_W];
      wdata_q <= bus.req_wdata;
    end
  end

  // Storage is touched only on the completing edge, so an abandoned request
  // never commits.
  main_memory_responder_mem_array #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .CLK   (CLK),
    .en    (complete),
    .we    (we_q),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Reads return the RAM output register; writebacks return the committed
  // word. Both hold until the next completion.
  assign bus.resp_we   = resp_we_q;
  assign bus.resp_data = rd_sel_q ? ram_rdata : wb_data_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Testbench for main_memory_responder: a LATENCY=4 instance for reset,
// latency, back-pressure, aliasing and reset-abort cases, and a LATENCY=1
// instance for back-to-back write/read traffic. Expected responses are
// queued at acceptance and checked by per-instance monitors.
module tb_main_memory_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 1024;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  main_memory_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  main_memory_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  main_memory_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .LATENCY(LAT_A)) dut_a (
    .CLK(CLK), .reset(reset), .bus(bus_a.slave));
  main_memory_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .LATENCY(LAT_B)) dut_b (
    .CLK(CLK), .reset(reset), .bus(bus_b.slave));

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_b = -1;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  logic [31:0] t6_addr [16] = '{
    32'h0000_0000, 32'h0000_0FFC, 32'h1234_5678, 32'h0000_0044,
    32'hFFFF_FFFF, 32'h0000_0200, 32'h8000_0104, 32'h0000_0ABC,
    32'h0000_0010, 32'h0000_0013, 32'h0000_07F0, 32'h0000_0330,
    32'hDEAD_0020, 32'h0000_0E00, 32'h0000_0124, 32'h0000_0888};
  logic [31:0] t6_data [16] = '{
    32'h0000_0001, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h1357_9BDF,
    32'h8000_0000, 32'h7FFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
    32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888,
    32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE, 32'h0102_0304};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? bus_b.req_ready : bus_a.req_ready;
  endfunction

  task automatic drive(input bit b, input logic v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (b) begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wd;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wd;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input bit b, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] expd);
    int n;
    exp_t e;
    n = 0;
    drive(b, 1'b1, we, addr, wd);
    while (!rdy(b) && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) begin
      check("issue_timeout_req_ready", {31'd0, rdy(b)}, 32'd1);
      drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
      return;
    end
    @(posedge CLK); #1;
    e.we = we; e.data = expd; e.acc = cyc;
    if (b) begin
      if (last_acc_b >= 0) check("b_accept_spacing", cyc - last_acc_b, 32'd3);
      last_acc_b = cyc;
      exp_b.push_back(e);
    end else begin
      exp_a.push_back(e);
    end
    drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_idle(input bit b);
    int n;
    n = 0;
    while (((b ? exp_b.size() : exp_a.size()) != 0 || !rdy(b)) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) check("wait_idle_timeout_req_ready", {31'd0, rdy(b)}, 32'd1);
  endtask

  task automatic wait_resp_a();
    int n;
    n = 0;
    while (!bus_a.resp_valid && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) check("wait_resp_timeout", {31'd0, bus_a.resp_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, bus_a.req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, bus_a.resp_valid}, 32'd0);
    check({tag, "_resp_we"},    {31'd0, bus_a.resp_we},    32'd0);
    check({tag, "_resp_data"},  bus_a.resp_data,           32'd0);
  endtask

  // Monitor for instance A.
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      prev_a = 1'b0;
    end else begin
      if (bus_a.resp_valid && !prev_a) begin
        if (exp_a.size() == 0) check("a_stray_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        else check("a_latency", cyc - exp_a[0].acc, LAT_A);
      end
      if (bus_a.resp_valid && bus_a.resp_ready && exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("a_resp_data", bus_a.resp_data, e.data);
        check("a_resp_we", {31'd0, bus_a.resp_we}, {31'd0, e.we});
      end
      prev_a = bus_a.resp_valid;
    end
  end

  // Monitor for instance B.
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      prev_b = 1'b0;
    end else begin
      if (bus_b.resp_valid && !prev_b) begin
        if (exp_b.size() == 0) check("b_stray_resp_valid", {31'd0, bus_b.resp_valid}, 32'd0);
        else check("b_latency", cyc - exp_b[0].acc, LAT_B);
      end
      if (bus_b.resp_valid && bus_b.resp_ready && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("b_resp_data", bus_b.resp_data, e.data);
        check("b_resp_we", {31'd0, bus_b.resp_we}, {31'd0, e.we});
      end
      prev_b = bus_b.resp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus_a.resp_ready = 1'b1;
    bus_b.resp_ready = 1'b1;
    #2;
    check_reset_outputs("por");
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;

    // Write then read back, latency checked by the monitor.
    issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
    wait_idle(1'b0);

    // Offset and high address bits ignored: 0x100B aliases index 2.
    issue(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h1234_5678);
    issue(1'b0, 1'b0, 32'h0000_100B, 32'h0,         32'h1234_5678);
    wait_idle(1'b0);

    // Back-pressure with an ignored request presented during RESP.
    bus_a.resp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
    wait_resp_a();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_BAD0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("bp_resp_valid", {31'd0, bus_a.resp_valid}, 32'd1);
      check("bp_resp_data", bus_a.resp_data, 32'hDEAD_BEEF);
      check("bp_resp_we", {31'd0, bus_a.resp_we}, 32'd0);
      check("bp_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus_a.resp_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("bp_release_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
    wait_idle(1'b0);

    // Reset during BUSY abandons the pending write.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0000_0001);
    wait_idle(1'b0);
    issue(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(posedge CLK); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("busy_rst");
    exp_a.delete();
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;
    issue(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0001);
    wait_idle(1'b0);

    // Reset during RESP drops the response but keeps the committed write.
    bus_a.resp_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 32'h55AA_55AA);
    wait_resp_a();
    reset = 1'b1;
    #1;
    check_reset_outputs("resp_rst");
    exp_a.delete();
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;
    bus_a.resp_ready = 1'b1;
    issue(1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'h55AA_55AA);
    wait_idle(1'b0);

    // LATENCY=1: back-to-back alternating write/read.
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 1'b1, t6_addr[i], t6_data[i], t6_data[i]);
      issue(1'b1, 1'b0, t6_addr[i], 32'h0,      t6_data[i]);
    end
    wait_idle(1'b1);
    wait_idle(1'b0);
    repeat (3) @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
